// File: rtl/lemon_pkg.sv
// Shared definitions for the LemonPC write-back stage.
//   LD_* : load funct3 encodings (size and signedness)
//   wb_state_t : write-back FSM states
package lemon_pkg;

   localparam int unsigned LD_F3_W = 3;

   localparam logic [LD_F3_W-1:0] LD_B  = 3'b000;
   localparam logic [LD_F3_W-1:0] LD_H  = 3'b001;
   localparam logic [LD_F3_W-1:0] LD_W  = 3'b010;
   localparam logic [LD_F3_W-1:0] LD_D  = 3'b011;
   localparam logic [LD_F3_W-1:0] LD_BU = 3'b100;
   localparam logic [LD_F3_W-1:0] LD_HU = 3'b101;
   localparam logic [LD_F3_W-1:0] LD_WU = 3'b110;
   // The remaining encoding has no load of its own and behaves as LD_D.
   localparam logic [LD_F3_W-1:0] LD_RSVD = 3'b111;

   typedef enum logic {
      WB_IDLE      = 1'b0,
      WB_LOAD_WAIT = 1'b1
   } wb_state_t;

endpackage

// File: rtl/load_align.sv
// Load data alignment: shifts the raw doubleword down by the byte offset,
// then sign- or zero-extends according to funct3. Purely combinational.
//   rdata   : raw 64-bit doubleword from memory
//   addr_lo : byte offset within the doubleword
//   funct3  : load size/sign encoding
//   data    : aligned, extended result
module load_align
   import lemon_pkg::*;
(
   input  logic [63:0]        rdata,
   input  logic [2:0]         addr_lo,
   input  logic [LD_F3_W-1:0] funct3,
   output logic [63:0]        data
);

   logic [63:0] shifted;

   // Bytes shifted past bit 63 fill with zero; misalignment is not flagged.
   assign shifted = rdata >> {addr_lo, 3'b000};

   always_comb begin
      data = shifted;
      case (funct3)
         LD_B:    data = {{56{shifted[7]}},  shifted[7:0]};
         LD_H:    data = {{48{shifted[15]}}, shifted[15:0]};
         LD_W:    data = {{32{shifted[31]}}, shifted[31:0]};
         LD_BU:   data = {56'd0, shifted[7:0]};
         LD_HU:   data = {48'd0, shifted[15:0]};
         LD_WU:   data = {32'd0, shifted[31:0]};
         default: data = shifted;
      endcase
   end

endmodule

// File: rtl/wb_stage.sv
// LemonPC write-back stage. Accepts completed instructions from execute,
// holds loads until the memory response, and drives the register file
// write port from registers. Reports RAW hazards for uncommitted writes.
//   clk, rst_n                : clock, async active-low reset
//   ex_valid/ex_ready         : execute handshake
//   ex_rd, ex_result          : destination and ALU result
//   ex_is_load, ex_funct3,
//   ex_addr_lo                : load descriptor
//   mem_rvalid, mem_rdata     : load response (single-cycle pulse)
//   rf_rd, rf_wen, rf_dataD   : register file write port (registered)
//   q_rs1/2, q_hazard1/2      : decode hazard query (combinational)
// Optional: define WB_TRACE_EN for a simulation-only commit trace and checks.
module wb_stage
   import lemon_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned DATA_WIDTH = 64
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ex_valid,
   output logic                  ex_ready,
   input  logic [ADDR_WIDTH-1:0] ex_rd,
   input  logic [DATA_WIDTH-1:0] ex_result,
   input  logic                  ex_is_load,
   input  logic [LD_F3_W-1:0]    ex_funct3,
   input  logic [2:0]            ex_addr_lo,
   input  logic                  mem_rvalid,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic [ADDR_WIDTH-1:0] rf_rd,
   output logic                  rf_wen,
   output logic [DATA_WIDTH-1:0] rf_dataD,
   input  logic [ADDR_WIDTH-1:0] q_rs1,
   input  logic [ADDR_WIDTH-1:0] q_rs2,
   output logic                  q_hazard1,
   output logic                  q_hazard2
);

   wb_state_t             state_q,        state_d;
   logic [ADDR_WIDTH-1:0] pend_rd_q,      pend_rd_d;
   logic [LD_F3_W-1:0]    pend_funct3_q,  pend_funct3_d;
   logic [2:0]            pend_addr_lo_q, pend_addr_lo_d;
   logic                  rf_wen_q,       rf_wen_d;
   logic [ADDR_WIDTH-1:0] rf_rd_q,        rf_rd_d;
   logic [DATA_WIDTH-1:0] rf_data_q,      rf_data_d;

   logic [DATA_WIDTH-1:0] load_data;
   logic                  xfer;

   load_align u_load_align (
      .rdata   (mem_rdata),
      .addr_lo (pend_addr_lo_q),
      .funct3  (pend_funct3_q),
      .data    (load_data)
   );

   assign ex_ready = (state_q == WB_IDLE);
   assign xfer     = ex_valid && ex_ready;

   // State and write-port registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= WB_IDLE;
         pend_rd_q      <= '0;
         pend_funct3_q  <= '0;
         pend_addr_lo_q <= '0;
         rf_wen_q       <= 1'b0;
         rf_rd_q        <= '0;
         rf_data_q      <= '0;
      end else begin
         state_q        <= state_d;
         pend_rd_q      <= pend_rd_d;
         pend_funct3_q  <= pend_funct3_d;
         pend_addr_lo_q <= pend_addr_lo_d;
         rf_wen_q       <= rf_wen_d;
         rf_rd_q        <= rf_rd_d;
         rf_data_q      <= rf_data_d;
      end
   end

   // Next-state and write-port logic; rf_wen is a one-cycle pulse per write.
   always_comb begin
      state_d        = state_q;
      pend_rd_d      = pend_rd_q;
      pend_funct3_d  = pend_funct3_q;
      pend_addr_lo_d = pend_addr_lo_q;
      rf_wen_d       = 1'b0;
      rf_rd_d        = rf_rd_q;
      rf_data_d      = rf_data_q;

      case (state_q)
         WB_IDLE: begin
            if (xfer) begin
               if (ex_is_load) begin
                  pend_rd_d      = ex_rd;
                  pend_funct3_d  = ex_funct3;
                  pend_addr_lo_d = ex_addr_lo;
                  state_d        = WB_LOAD_WAIT;
               end else begin
                  rf_rd_d   = ex_rd;
                  rf_data_d = ex_result;
                  rf_wen_d  = (ex_rd != '0);
               end
            end
         end
         WB_LOAD_WAIT: begin
            if (mem_rvalid) begin
               rf_rd_d   = pend_rd_q;
               rf_data_d = load_data;
               rf_wen_d  = (pend_rd_q != '0);
               state_d   = WB_IDLE;
            end
         end
         default: state_d = WB_IDLE;
      endcase
   end

   // Hazard query: a pending load or the write in flight this cycle; x0 never hazards.
   always_comb begin
      q_hazard1 = (q_rs1 != '0) &&
                  (((state_q == WB_LOAD_WAIT) && (pend_rd_q == q_rs1)) ||
                   (rf_wen_q && (rf_rd_q == q_rs1)));
      q_hazard2 = (q_rs2 != '0) &&
                  (((state_q == WB_LOAD_WAIT) && (pend_rd_q == q_rs2)) ||
                   (rf_wen_q && (rf_rd_q == q_rs2)));
   end

   assign rf_wen   = rf_wen_q;
   assign rf_rd    = rf_rd_q;
   assign rf_dataD = rf_data_q;

`ifdef WB_TRACE_EN
   // Simulation-only commit trace and protocol checks.
   always @(posedge clk) begin
      if (rst_n) begin
         if (rf_wen_q)
            $display("wb x%0d <= 0x%0x", rf_rd_q, rf_data_q);
         if ((state_q == WB_IDLE) && mem_rvalid)
            $error("wb_stage: mem_rvalid while idle");
         if (xfer && ex_is_load && (ex_funct3 == LD_RSVD))
            $error("wb_stage: load with funct3 111");
      end
   end
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios with literal
// expectations, then randomized traffic against a transaction-level model.
module tb_wb_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ex_valid;
   logic        ex_ready;
   logic [4:0]  ex_rd;
   logic [63:0] ex_result;
   logic        ex_is_load;
   logic [2:0]  ex_funct3;
   logic [2:0]  ex_addr_lo;
   logic        mem_rvalid;
   logic [63:0] mem_rdata;
   logic [4:0]  rf_rd;
   logic        rf_wen;
   logic [63:0] rf_dataD;
   logic [4:0]  q_rs1, q_rs2;
   logic        q_hazard1, q_hazard2;

   int n_tests = 0;
   int n_fail  = 0;

   // Model state: is a load outstanding, what it is, and the write in flight.
   bit          m_busy;
   int          m_prd, m_pf3, m_poff;
   bit          m_wen;
   int          m_rd;
   logic [63:0] m_data;

   always #5 clk = ~clk;

   wb_stage #(.ADDR_WIDTH(5), .DATA_WIDTH(64)) dut (
      .clk(clk), .rst_n(rst_n),
      .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_rd(ex_rd),
      .ex_result(ex_result), .ex_is_load(ex_is_load), .ex_funct3(ex_funct3),
      .ex_addr_lo(ex_addr_lo), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .rf_rd(rf_rd), .rf_wen(rf_wen), .rf_dataD(rf_dataD),
      .q_rs1(q_rs1), .q_rs2(q_rs2), .q_hazard1(q_hazard1), .q_hazard2(q_hazard2)
   );

   // Load result from size/sign rules: take N bytes starting at the offset.
   function automatic logic [63:0] m_ext(logic [63:0] raw, int off, int f3);
      int          nbytes;
      bit          sgn;
      logic [63:0] v;
      logic [63:0] mask;
      nbytes = (f3 == 7) ? 8 : (1 << (f3 % 4));
      sgn    = (f3 < 4) || (f3 == 7);
      v      = raw >> (8 * off);
      if (nbytes == 8) return v;
      mask = (64'd1 << (8 * nbytes)) - 64'd1;
      v    = v & mask;
      if (sgn && v[8*nbytes-1]) v = v | ~mask;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic m_reset();
      m_busy = 0; m_prd = 0; m_pf3 = 0; m_poff = 0;
      m_wen = 0; m_rd = 0; m_data = '0;
   endtask

   function automatic bit m_haz(int rs);
      return (rs != 0) && ((m_busy && m_prd == rs) || (m_wen && m_rd == rs));
   endfunction

   // One clock cycle: drive at the falling edge, compare, then advance the model
   // by what the coming rising edge will do.
   task automatic cycle(input bit rst, input bit v, input int rd, input logic [63:0] res,
                        input bit ld, input int f3, input int off,
                        input bit rv, input logic [63:0] rdat,
                        input int rs1, input int rs2);
      @(negedge clk);
      rst_n = rst; ex_valid = v; ex_rd = 5'(rd); ex_result = res; ex_is_load = ld;
      ex_funct3 = 3'(f3); ex_addr_lo = 3'(off); mem_rvalid = rv; mem_rdata = rdat;
      q_rs1 = 5'(rs1); q_rs2 = 5'(rs2);
      if (!rst) m_reset();
      #1;
      chk("ex_ready",  64'(ex_ready),  64'(!m_busy));
      chk("rf_wen",    64'(rf_wen),    64'(m_wen));
      chk("rf_rd",     64'(rf_rd),     64'(m_rd));
      chk("rf_dataD",  rf_dataD,       m_data);
      chk("q_hazard1", 64'(q_hazard1), 64'(m_haz(rs1)));
      chk("q_hazard2", 64'(q_hazard2), 64'(m_haz(rs2)));
      if (rst) begin
         if (!m_busy && v) begin
            if (ld) begin
               m_busy = 1; m_prd = rd; m_pf3 = f3; m_poff = off; m_wen = 0;
            end else begin
               m_rd = rd; m_data = res; m_wen = (rd != 0);
            end
         end else if (m_busy && rv) begin
            m_busy = 0; m_rd = m_prd; m_data = m_ext(rdat, m_poff, m_pf3);
            m_wen = (m_prd != 0);
         end else begin
            m_wen = 0;
         end
      end
   endtask

   task automatic idle(input int rs1 = 0, input int rs2 = 0);
      cycle(1, 0, 0, '0, 0, 0, 0, 0, '0, rs1, rs2);
   endtask

   initial begin
      rst_n = 0; ex_valid = 0; ex_rd = '0; ex_result = '0; ex_is_load = 0;
      ex_funct3 = '0; ex_addr_lo = '0; mem_rvalid = 0; mem_rdata = '0;
      q_rs1 = '0; q_rs2 = '0;
      m_reset();

      // Reset values.
      cycle(0, 0, 0, '0, 0, 0, 0, 0, '0, 3, 0);
      cycle(0, 0, 0, '0, 0, 0, 0, 0, '0, 0, 0);
      chk("rst ex_ready", 64'(ex_ready), 64'd1);
      chk("rst rf_wen",   64'(rf_wen),   64'd0);
      chk("rst rf_dataD", rf_dataD,      64'd0);

      // ALU write then three back-to-back transfers.
      cycle(1, 1, 5, 64'h1234, 0, 0, 0, 0, '0, 0, 0);
      cycle(1, 1, 1, 64'h11, 0, 0, 0, 0, '0, 5, 0);
      chk("alu wen",  64'(rf_wen),   64'd1);
      chk("alu rd",   64'(rf_rd),    64'd5);
      chk("alu data", rf_dataD,      64'h1234);
      chk("alu haz",  64'(q_hazard1), 64'd1);
      cycle(1, 1, 2, 64'h22, 0, 0, 0, 0, '0, 0, 0);
      cycle(1, 1, 3, 64'h33, 0, 0, 0, 0, '0, 0, 0);
      idle();
      chk("b2b rd3",   64'(rf_rd),  64'd3);
      chk("b2b data3", rf_dataD,    64'h33);

      // LB sign-extension.
      cycle(1, 1, 9, '0, 1, 0, 3, 0, '0, 0, 0);
      cycle(1, 0, 0, '0, 0, 0, 0, 1, 64'h0000_0000_8000_0000, 0, 0);
      idle();
      chk("lb data", rf_dataD, 64'hFFFF_FFFF_FFFF_FF80);
      chk("lb rd",   64'(rf_rd), 64'd9);

      // LHU and LWU zero-extension.
      cycle(1, 1, 12, '0, 1, 5, 6, 0, '0, 0, 0);
      cycle(1, 0, 0, '0, 0, 0, 0, 1, 64'hBEEF_0000_0000_0000, 0, 0);
      idle();
      chk("lhu data", rf_dataD, 64'h0000_0000_0000_BEEF);
      cycle(1, 1, 13, '0, 1, 6, 4, 0, '0, 0, 0);
      cycle(1, 0, 0, '0, 0, 0, 0, 1, 64'hBEEF_0000_0000_0000, 0, 0);
      idle();
      chk("lwu data", rf_dataD, 64'h0000_0000_BEEF_0000);

      // Stall: load to x7, response four cycles late, ALU op queued behind it.
      cycle(1, 1, 7, '0, 1, 3, 0, 0, '0, 7, 0);
      for (int i = 0; i < 4; i++) begin
         cycle(1, 1, 10, 64'hAAAA, 0, 0, 0, 0, '0, 7, 0);
         chk("stall ready", 64'(ex_ready),  64'd0);
         chk("stall haz1",  64'(q_hazard1), 64'd1);
         chk("stall haz2",  64'(q_hazard2), 64'd0);
      end
      cycle(1, 1, 10, 64'hAAAA, 0, 0, 0, 1, 64'h1122_3344_5566_7788, 7, 0);
      cycle(1, 1, 10, 64'hAAAA, 0, 0, 0, 0, '0, 7, 0);
      chk("ld7 wen",   64'(rf_wen),   64'd1);
      chk("ld7 data",  rf_dataD,      64'h1122_3344_5566_7788);
      chk("ld7 ready", 64'(ex_ready), 64'd1);
      idle();
      chk("queued rd",   64'(rf_rd), 64'd10);
      chk("queued data", rf_dataD,   64'hAAAA);

      // x0 writes are suppressed; the load still completes.
      cycle(1, 1, 0, 64'h55, 0, 0, 0, 0, '0, 0, 0);
      cycle(1, 1, 0, '0, 1, 3, 0, 0, '0, 0, 0);
      chk("x0 alu wen", 64'(rf_wen), 64'd0);
      cycle(1, 0, 0, '0, 0, 0, 0, 1, 64'hFFFF, 0, 0);
      idle();
      chk("x0 ld wen",   64'(rf_wen),   64'd0);
      chk("x0 ld ready", 64'(ex_ready), 64'd1);

      // Reset while a load is pending drops it.
      cycle(1, 1, 4, '0, 1, 3, 0, 0, '0, 4, 0);
      cycle(0, 0, 0, '0, 0, 0, 0, 1, 64'hDEAD, 4, 0);
      chk("rstld ready", 64'(ex_ready),  64'd1);
      chk("rstld haz1",  64'(q_hazard1), 64'd0);
      chk("rstld rd",    64'(rf_rd),     64'd0);
      cycle(1, 0, 0, '0, 0, 0, 0, 1, 64'hDEAD, 4, 0);
      idle(4);
      chk("rstld wen", 64'(rf_wen), 64'd0);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         cycle(($urandom_range(0, 299) != 0),
               ($urandom_range(0, 3) != 0),
               int'($urandom_range(0, 31)),
               {$urandom, $urandom},
               ($urandom_range(0, 2) == 0),
               int'($urandom_range(0, 7)),
               int'($urandom_range(0, 7)),
               ($urandom_range(0, 2) == 0),
               {$urandom, $urandom},
               int'($urandom_range(0, 31)),
               int'($urandom_range(0, 31)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
